audio_arbiter: RTL and testbench

//  Shares one tone output and one note-duration timer between NUM_REQ jingle sequencers
//  (fail, success, grab, ...), for example the fail-jingle FSM. Game-control requests
//  are granted one at a time at fixed priority. The arbiter drives the granted jingle's

---
 rtl/audio_pkg.sv | 15 +
 rtl/note_timer.sv | 29 ++
 rtl/audio_arbiter.sv | 119 +++++++++++
 tb/tb_audio_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio arbiter and the jingle sequencers it serves.
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PLAY    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_GAP     = 2'd3
  } arb_state_t;

  localparam int AUDIO_NOTE_W        = 7;
  localparam int NOTE_CYCLES_DEFAULT = 12_500_000;  // 0.25 s @ 50 MHz
  localparam int GAP_CYCLES_DEFAULT  = 2_500_000;

endpackage

// File: rtl/note_timer.sv
// Clearable up-counter that pulses tick on the cycle it sits at the terminal count
// while enabled, and wraps to zero on that tick.
module note_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = enable && !clear && (cnt == terminal);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/audio_arbiter.sv
// Fixed-priority arbiter sharing one tone generator and one note timer between
// NUM_REQ jingle sequencers; one jingle plays at a time, followed by a silent gap.
module audio_arbiter
  import audio_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int NOTE_W      = AUDIO_NOTE_W,
  parameter int NOTE_CYCLES = NOTE_CYCLES_DEFAULT,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEFAULT,
  parameter int CNT_W       = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        play_req,
  output logic [NUM_REQ-1:0]        play_ack,
  output logic [NUM_REQ-1:0]        jingle_start,
  input  logic [NUM_REQ-1:0]        jingle_en,
  input  logic [NUM_REQ*NOTE_W-1:0] jingle_note,
  input  logic [NUM_REQ-1:0]        jingle_done,
  output logic [NUM_REQ-1:0]        note_done,
  output logic                      tone_en,
  output logic [NOTE_W-1:0]         tone_note,
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] NOTE_TC = CNT_W'(NOTE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [NUM_REQ-1:0] armed_q, ack_q, ack_d;
  logic [NUM_REQ-1:0] eligible, grant_oh;
  logic               in_play, en_g, done_g;
  logic               tmr_clear, tmr_enable, tmr_tick;
  logic [CNT_W-1:0]   tmr_terminal;

  function automatic logic [GW-1:0] lowest_set(input logic [NUM_REQ-1:0] v);
    lowest_set = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = GW'(i);
    end
  endfunction

  // A request is only eligible after it has been seen low, so each rising edge plays once.
  assign eligible = play_req & armed_q;
  assign grant_oh = NUM_REQ'(1) << grant_q;
  assign en_g     = jingle_en[grant_q];
  assign done_g   = jingle_done[grant_q];
  assign in_play  = (state_q == ST_PLAY);

  assign jingle_start = in_play ? grant_oh : '0;
  assign note_done    = (in_play && tmr_tick) ? grant_oh : '0;
  assign tone_en      = in_play && en_g;
  assign tone_note    = tone_en ? jingle_note[int'(grant_q) * NOTE_W +: NOTE_W] : '0;
  assign play_ack     = ack_q;
  assign busy         = (state_q != ST_IDLE);

  note_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .terminal (tmr_terminal),
    .tick     (tmr_tick)
  );

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    ack_d        = '0;
    tmr_clear    = 1'b1;
    tmr_enable   = 1'b0;
    tmr_terminal = NOTE_TC;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_d = lowest_set(eligible);
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // The note timer only runs while the jingle is sounding; silence restarts it.
        tmr_clear  = !en_g;
        tmr_enable = en_g;
        if (done_g) begin
          ack_d   = grant_oh;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (!done_g) state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
      end
      ST_GAP: begin
        tmr_clear    = 1'b0;
        tmr_enable   = 1'b1;
        tmr_terminal = GAP_TC;
        if (tmr_tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      armed_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      armed_q <= ~play_req | (armed_q & ~ack_q);
    end
  end

endmodule

// File: tb/tb_audio_arbiter.sv
// Self-checking bench: behavioural jingle sequencers, a cycle-level reference model of
// the arbitration rules, and directed scenarios with hand-computed timing.
module tb_audio_arbiter;

  localparam int NUM_REQ = 4;
  localparam int NOTE_W  = 7;
  localparam int NC      = 4;
  localparam int GC      = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        play_req, play_ack, jingle_start, jingle_en, jingle_done, note_done;
  logic [NUM_REQ*NOTE_W-1:0] jingle_note;
  logic                      tone_en, busy;
  logic [NOTE_W-1:0]         tone_note;

  // Jingle models (0 idle, 1 playing, 2 done) and bench overrides.
  int                 j_phase [NUM_REQ];
  int                 j_idx   [NUM_REQ];
  int                 nnotes  [NUM_REQ];
  logic [NUM_REQ-1:0] force_en, force_done;
  logic [NOTE_W-1:0]  force_note;
  logic [NUM_REQ-1:0] js_s, js_nd;
  logic               js_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  audio_arbiter #(
    .NUM_REQ(NUM_REQ), .NOTE_W(NOTE_W), .NOTE_CYCLES(NC), .GAP_CYCLES(GC), .CNT_W(24)
  ) dut (
    .clk(clk), .reset(reset), .play_req(play_req), .play_ack(play_ack),
    .jingle_start(jingle_start), .jingle_en(jingle_en), .jingle_note(jingle_note),
    .jingle_done(jingle_done), .note_done(note_done), .tone_en(tone_en),
    .tone_note(tone_note), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [NOTE_W-1:0] note_code(input int j, input int k);
    return NOTE_W'(16 + 8 * j + k);
  endfunction

  always_comb begin
    jingle_en   = force_en;
    jingle_done = force_done;
    jingle_note = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (j_phase[i] == 1) begin
        jingle_en[i] = 1'b1;
        jingle_note[i*NOTE_W +: NOTE_W] = note_code(i, j_idx[i]);
      end else if (force_en[i]) begin
        jingle_note[i*NOTE_W +: NOTE_W] = force_note;
      end
      if (j_phase[i] == 2) jingle_done[i] = 1'b1;
    end
  end

  // Jingle sequencers: sample start/note_done at the edge, react just after it.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      j_phase[i] = 0;
      j_idx[i]   = 0;
    end
    forever begin
      @(posedge clk);
      js_s = jingle_start;
      js_nd = note_done;
      js_r = reset;
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (js_r) begin
          j_phase[i] = 0;
          j_idx[i]   = 0;
        end else if (j_phase[i] == 0) begin
          if (js_s[i]) begin
            j_idx[i]   = 0;
            j_phase[i] = (nnotes[i] == 0) ? 2 : 1;
          end
        end else if (j_phase[i] == 1) begin
          if (!js_s[i]) j_phase[i] = 0;
          else if (js_nd[i]) begin
            j_idx[i]++;
            if (j_idx[i] == nnotes[i]) j_phase[i] = 2;
          end
        end else if (!js_s[i]) begin
          j_phase[i] = 0;
        end
      end
    end
  end

  // Reference model + per-cycle compare + statistics, all on the falling edge.
  int m_mode, m_owner, m_run, m_gap;   // mode: 0 idle, 1 playing, 2 releasing, 3 gap
  logic [NUM_REQ-1:0] m_armed, m_ack, m_nxt_ack, m_elig, prev_start;
  logic [NUM_REQ-1:0] exp_start, exp_nd;
  logic exp_ten;
  logic [NOTE_W-1:0] exp_note;
  bit started = 0;
  int cyc = 0;
  int nd_cnt [NUM_REQ], ack_cnt [NUM_REQ], rise_cyc [NUM_REQ], ack_cyc [NUM_REQ];
  int ten_cnt = 0, busy_cnt = 0, cnt55 = 0;
  bit found;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      nd_cnt[i] = 0; ack_cnt[i] = 0; rise_cyc[i] = -1; ack_cyc[i] = -1;
    end
    prev_start = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (started) begin
        exp_start = (m_mode == 1) ? NUM_REQ'(1) << m_owner : '0;
        exp_ten   = (m_mode == 1) && (jingle_en[m_owner] === 1'b1);
        exp_note  = exp_ten ? jingle_note[m_owner*NOTE_W +: NOTE_W] : '0;
        exp_nd    = (exp_ten && m_run == NC - 1) ? NUM_REQ'(1) << m_owner : '0;
        check("cyc.jingle_start", 32'(jingle_start), 32'(exp_start));
        check("cyc.play_ack", 32'(play_ack), 32'(m_ack));
        check("cyc.note_done", 32'(note_done), 32'(exp_nd));
        check("cyc.tone", 32'({tone_en, tone_note}), 32'({exp_ten, exp_note}));
        check("cyc.busy", 32'(busy), 32'(m_mode != 0));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (note_done[i] === 1'b1) nd_cnt[i]++;
        if (play_ack[i] === 1'b1) begin ack_cnt[i]++; ack_cyc[i] = cyc; end
        if (jingle_start[i] === 1'b1 && prev_start[i] !== 1'b1) rise_cyc[i] = cyc;
      end
      prev_start = jingle_start;
      if (tone_en === 1'b1) ten_cnt++;
      if (busy === 1'b1) busy_cnt++;
      if (tone_note === 7'h55) cnt55++;
      // Advance the model using the inputs the DUT will sample on the next edge.
      if (reset) begin
        m_mode = 0; m_owner = 0; m_run = 0; m_gap = 0; m_armed = '0; m_ack = '0;
        started = 1;
      end else if (started) begin
        m_nxt_ack = '0;
        case (m_mode)
          0: begin
            m_elig = play_req & m_armed;
            found = 0;
            for (int i = 0; i < NUM_REQ; i++) begin
              if (m_elig[i] && !found) begin m_owner = i; found = 1; end
            end
            if (found) begin m_mode = 1; m_run = 0; end
          end
          1: begin
            if (jingle_en[m_owner]) m_run = (m_run == NC - 1) ? 0 : m_run + 1;
            else m_run = 0;
            if (jingle_done[m_owner]) begin m_nxt_ack[m_owner] = 1'b1; m_mode = 2; end
          end
          2: if (!jingle_done[m_owner]) begin m_mode = (GC == 0) ? 0 : 3; m_gap = 0; end
          default: if (m_gap == GC - 1) m_mode = 0; else m_gap++;
        endcase
        m_armed = ~play_req | (m_armed & ~m_ack);
        m_ack = m_nxt_ack;
      end
    end
  end

  // Stimulus helpers.
  int s_nd [NUM_REQ], s_ack [NUM_REQ];
  int s_ten, s_busy, s_55, t0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    for (int i = 0; i < NUM_REQ; i++) begin s_nd[i] = nd_cnt[i]; s_ack[i] = ack_cnt[i]; end
    s_ten = ten_cnt; s_busy = busy_cnt; s_55 = cnt55;
    t0 = cyc + 1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin step(); n++; end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    play_req = 4'b0001;
    force_en = '0; force_done = '0; force_note = '0;
    nnotes[0] = 1; nnotes[1] = 2; nnotes[2] = 2; nnotes[3] = 1;

    // Reset with req[0] held high: no replay afterwards.
    repeat (3) step();
    reset = 1'b0;
    check("reset.outputs", 32'({jingle_start, play_ack, note_done, tone_en, tone_note, busy}), 32'd0);
    snapshot();
    repeat (6) step();
    check("reset.held_req_no_play", 32'(busy_cnt - s_busy), 32'd0);
    play_req = '0;
    step();

    // Single request on jingle 2 (two notes).
    snapshot();
    play_req = 4'b0100;
    step();
    wait_idle("single.idle");
    check("single.start_latency", 32'(rise_cyc[2] - t0), 32'd1);
    check("single.note_done_count", 32'(nd_cnt[2] - s_nd[2]), 32'd2);
    check("single.tone_en_cycles", 32'(ten_cnt - s_ten), 32'd8);
    check("single.ack_count", 32'(ack_cnt[2] - s_ack[2]), 32'd1);
    check("single.ack_cycle", 32'(ack_cyc[2] - t0), 32'd11);
    check("single.busy_cycles", 32'(busy_cnt - s_busy), 32'd15);
    play_req = '0;
    step();

    // Simultaneous requests 1 and 3: jingle 1 first, gap, then jingle 3.
    nnotes[1] = 1;
    snapshot();
    play_req = 4'b1010;
    step();
    wait_idle("simul.first_idle");
    step();
    wait_idle("simul.second_idle");
    check("simul.start1", 32'(rise_cyc[1] - t0), 32'd1);
    check("simul.start3", 32'(rise_cyc[3] - t0), 32'd13);
    check("simul.ack1", 32'(ack_cnt[1] - s_ack[1]), 32'd1);
    check("simul.ack3", 32'(ack_cnt[3] - s_ack[3]), 32'd1);
    check("simul.nd3", 32'(nd_cnt[3] - s_nd[3]), 32'd1);
    play_req = '0;
    step();

    // Hold req[0] after ack: no replay; a one-cycle drop re-arms it.
    play_req = 4'b0001;
    step();
    wait_idle("hold.idle");
    snapshot();
    repeat (8) step();
    check("hold.no_replay", 32'(busy_cnt - s_busy), 32'd0);
    play_req = '0;
    step();
    snapshot();
    play_req = 4'b0001;
    step();
    wait_idle("hold.replay_idle");
    check("hold.replay_ack", 32'(ack_cnt[0] - s_ack[0]), 32'd1);
    play_req = '0;
    step();

    // Isolation: jingle 0 sounds 7'h55 while jingle 2 owns the tone.
    snapshot();
    play_req = 4'b0100;
    repeat (3) step();
    force_en = 4'b0001;
    force_note = 7'h55;
    wait_idle("iso.idle");
    force_en = '0;
    check("iso.no_55", 32'(cnt55 - s_55), 32'd0);
    check("iso.nd0", 32'(nd_cnt[0] - s_nd[0]), 32'd0);
    check("iso.nd2", 32'(nd_cnt[2] - s_nd[2]), 32'd2);
    play_req = '0;
    step();

    // Request dropped mid-play still completes and acks.
    snapshot();
    play_req = 4'b1000;
    repeat (4) step();
    play_req = '0;
    wait_idle("abort.idle");
    check("abort.ack3", 32'(ack_cnt[3] - s_ack[3]), 32'd1);
    check("abort.nd3", 32'(nd_cnt[3] - s_nd[3]), 32'd1);
    step();

    // Immediate done on jingle 1: ack two cycles after request, no notes.
    nnotes[1] = 0;
    force_done = 4'b0010;
    step();
    snapshot();
    play_req = 4'b0010;
    step();
    step();
    check("imm.ack_now", 32'(play_ack), 32'h2);
    force_done = '0;
    wait_idle("imm.idle");
    check("imm.ack_cycle", 32'(ack_cyc[1] - t0), 32'd2);
    check("imm.no_note_done", 32'(nd_cnt[1] - s_nd[1]), 32'd0);
    play_req = '0;
    step();

    // Reset in the middle of a note.
    play_req = 4'b0100;
    repeat (4) step();
    check("rst_mid.pre_tone", 32'(tone_en), 32'd1);
    reset = 1'b1;
    step();
    check("rst_mid.outputs", 32'({jingle_start, play_ack, note_done, tone_en, tone_note, busy}), 32'd0);
    reset = 1'b0;
    snapshot();
    repeat (5) step();
    check("rst_mid.no_replay", 32'(busy_cnt - s_busy), 32'd0);
    play_req = '0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
